// File: rtl/ram_bist_pkg.sv
// ---------------------------------------------------------------------------
// ram_bist_pkg
// Shared types and helpers for the RAM built-in self-test engine.
//   bist_state_t : march-test sequencer states
//   PAT_W        : working width of the pattern helper. Callers zero-extend
//                  into it and truncate the result back to their data width.
//   pattern()    : per-address test pattern, address XOR seed
// ---------------------------------------------------------------------------
package ram_bist_pkg;

  // Sequencer states. The order follows the march test:
  // ascending write, ascending read/write, descending read, then one
  // drain cycle to finish the last compare.
  typedef enum logic [2:0] {
    IDLE,
    W_UP,
    RW_UP,
    R_DN,
    DRAIN,
    DONE
  } bist_state_t;

  localparam int PAT_W = 32;

  // Pattern for one address. Both operands arrive zero-extended to PAT_W.
  // The caller keeps only its DATA_W low bits, so a narrow address is
  // zero-extended and a wide one is truncated.
  function automatic logic [PAT_W-1:0] pattern(input logic [PAT_W-1:0] addr,
                                               input logic [PAT_W-1:0] seed);
    return addr ^ seed;
  endfunction

endpackage

// File: rtl/ram_bist_checker.sv
// ---------------------------------------------------------------------------
// ram_bist_checker
// Compare pipeline for the BIST engine. A read issued in one cycle has its
// expected data and address registered at that cycle's closing edge. The
// RAM returns read data one cycle later, and the comparison is made at the
// following edge. Miscompares feed a saturating error counter and a
// first-failing-address register.
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   clear      in   synchronous clear at test start (same effect as rst)
//   issue_v    in   a read is being issued this cycle
//   exp        in   DATA_W  value that read should return
//   addr       in   ADDR_W  address of that read
//   rd_data    in   DATA_W  registered RAM read data
//   err_count  out  ERR_CNT_W  miscompare count, saturating at all-ones
//   fail_addr  out  ADDR_W     address of the first miscompare, 0 if none
// ---------------------------------------------------------------------------
module ram_bist_checker #(
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 issue_v,
  input  logic [DATA_W-1:0]    exp,
  input  logic [ADDR_W-1:0]    addr,
  input  logic [DATA_W-1:0]    rd_data,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [ADDR_W-1:0]    fail_addr
);

  logic [DATA_W-1:0] exp_q;
  logic [ADDR_W-1:0] addr_q;
  logic              cmp_v;
  logic              fail_seen;
  logic              miscompare;

  // The RAM's read data is valid in the same cycle as cmp_v, because both
  // were launched by the same edge.
  assign miscompare = cmp_v && (rd_data != exp_q);

  // Pipeline stage: capture what the in-flight read should return and where
  // it came from. It runs every cycle with no bubbles, so a read issued on
  // the last cycle of one march element is compared during the first cycle
  // of the next element.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      exp_q  <= '0;
      addr_q <= '0;
      cmp_v  <= 1'b0;
    end else begin
      exp_q  <= exp;
      addr_q <= addr;
      cmp_v  <= issue_v;
    end
  end

  // Error accounting. The counter holds at all-ones instead of wrapping, so
  // a heavily broken RAM never reads back as nearly clean. fail_seen locks
  // fail_addr after the first miscompare.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      err_count <= '0;
      fail_addr <= '0;
      fail_seen <= 1'b0;
    end else if (miscompare) begin
      if (err_count != '1) begin
        err_count <= err_count + ERR_CNT_W'(1);
      end
      if (!fail_seen) begin
        fail_seen <= 1'b1;
        fail_addr <= addr_q;
      end
    end
  end

endmodule

// File: rtl/ram_bist_engine.sv
// ---------------------------------------------------------------------------
// ram_bist_engine
// Built-in self-test initiator for one single-port RAM. The engine runs a
// three-element march test on start:
//   W_UP  : write P(a) for ascending a
//   RW_UP : write ~P(a) and read old P(a) for ascending a
//   R_DN  : read ~P(a) for descending a
// It then reports pass/fail, the error count and the first failing address.
// P(a) = a XOR seed.
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   start, seed     begin a test and the pattern seed captured with it
//   busy, done      test running / finished, done held until restart
//   pass            1 when done and no miscompares were seen
//   err_count       saturating miscompare count
//   fail_addr       first miscompare address
//   mem_write_en, mem_address, mem_write_data   RAM drive
//   mem_read_data   registered RAM read data, 1-cycle latency
// ---------------------------------------------------------------------------
module ram_bist_engine
  import ram_bist_pkg::*;
#(
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DATA_W-1:0]    seed,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [ADDR_W-1:0]    fail_addr,
  output logic                 mem_write_en,
  output logic [ADDR_W-1:0]    mem_address,
  output logic [DATA_W-1:0]    mem_write_data,
  input  logic [DATA_W-1:0]    mem_read_data
);

  bist_state_t       state;
  bist_state_t       state_next;
  logic [ADDR_W-1:0] addr_cnt;
  logic [ADDR_W-1:0] addr_next;
  logic [DATA_W-1:0] seed_q;
  logic [DATA_W-1:0] pat;
  logic              start_ok;
  logic              last_addr;
  logic              first_addr;
  logic              issue_v;
  logic [DATA_W-1:0] exp_data;

  // start only counts when no test is running. The same condition clears
  // the checker, so results drop at the sampling edge of a restart.
  assign start_ok   = start && ((state == IDLE) || (state == DONE));
  assign last_addr  = (addr_cnt == '1);
  assign first_addr = (addr_cnt == '0);
  assign pat        = DATA_W'(pattern(PAT_W'(addr_cnt), PAT_W'(seed_q)));

  // The RAM address is the counter register itself, with no extra decode
  // in front of the RAM pins.
  assign mem_address = addr_cnt;
  assign pass        = done && (err_count == '0);

  // State register, address counter and seed capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      addr_cnt <= '0;
      seed_q   <= '0;
    end else begin
      state    <= state_next;
      addr_cnt <= addr_next;
      if (start_ok) begin
        seed_q <= seed;
      end
    end
  end

  // Next-state and next-address logic. Each element lasts exactly 2**ADDR_W
  // cycles. The state advances on the cycle that the counter reaches its
  // boundary value. Ascending elements wrap the counter back to 0.
  // Leaving RW_UP loads all-ones so that R_DN starts at the top address.
  // R_DN's final decrement wraps to all-ones on the way into DRAIN.
  always_comb begin
    state_next = state;
    addr_next  = addr_cnt;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_next = W_UP;
          addr_next  = '0;
        end
      end
      W_UP: begin
        addr_next = addr_cnt + ADDR_W'(1);
        if (last_addr) begin
          state_next = RW_UP;
        end
      end
      RW_UP: begin
        if (last_addr) begin
          state_next = R_DN;
          addr_next  = '1;
        end else begin
          addr_next = addr_cnt + ADDR_W'(1);
        end
      end
      R_DN: begin
        addr_next = addr_cnt - ADDR_W'(1);
        if (first_addr) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        state_next = DONE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output decode. Only the two write elements enable RAM writes. The
  // read-issuing elements hand the checker the value the RAM should return.
  // RW_UP expects the old P(a), because the RAM returns pre-write data on a
  // same-address write.
  always_comb begin
    busy           = 1'b0;
    done           = 1'b0;
    mem_write_en   = 1'b0;
    mem_write_data = '0;
    issue_v        = 1'b0;
    exp_data       = '0;
    case (state)
      W_UP: begin
        busy           = 1'b1;
        mem_write_en   = 1'b1;
        mem_write_data = pat;
      end
      RW_UP: begin
        busy           = 1'b1;
        mem_write_en   = 1'b1;
        mem_write_data = ~pat;
        issue_v        = 1'b1;
        exp_data       = pat;
      end
      R_DN: begin
        busy     = 1'b1;
        issue_v  = 1'b1;
        exp_data = ~pat;
      end
      DRAIN: begin
        busy = 1'b1;
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  ram_bist_checker #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .ERR_CNT_W(ERR_CNT_W)
  ) u_checker (
    .clk      (clk),
    .rst      (rst),
    .clear    (start_ok),
    .issue_v  (issue_v),
    .exp      (exp_data),
    .addr     (addr_cnt),
    .rd_data  (mem_read_data),
    .err_count(err_count),
    .fail_addr(fail_addr)
  );

endmodule

// File: tb/tb_ram_bist_engine.sv
// ---------------------------------------------------------------------------
// tb_ram_bist_engine
// Directed bench for ram_bist_engine at ADDR_W=4, DATA_W=4. The main
// instance drives a 16x4 RAM model. The model can hold cell 5 bit 0 at 0 or
// block all writes. A second instance with a 2-bit error counter runs beside
// the main one. Its read data is tied to 0, which looks like a RAM that never
// accepts writes, and it always uses seed 4'hF.
// ---------------------------------------------------------------------------
module tb_ram_bist_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] seed;
  logic       busy, done, pass;
  logic [7:0] err_count;
  logic [3:0] fail_addr;
  logic       mem_write_en;
  logic [3:0] mem_address, mem_write_data, mem_read_data;

  logic       busy_s, done_s, pass_s;
  logic [1:0] err_s;
  logic [3:0] fail_s;
  logic       we_s;
  logic [3:0] addr_s, wdata_s;
  logic [3:0] rdata_s;
  logic [3:0] seed_s;

  logic       stuck5;
  logic       block_wr;
  logic [3:0] ram [16];

  int total = 0;
  int bad   = 0;

  assign rdata_s = 4'h0;
  assign seed_s  = 4'hF;

  always #5 clk = ~clk;

  ram_bist_engine #(.ADDR_W(4), .DATA_W(4), .ERR_CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .seed(seed),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_addr(fail_addr),
    .mem_write_en(mem_write_en), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  ram_bist_engine #(.ADDR_W(4), .DATA_W(4), .ERR_CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .seed(seed_s),
    .busy(busy_s), .done(done_s), .pass(pass_s),
    .err_count(err_s), .fail_addr(fail_s),
    .mem_write_en(we_s), .mem_address(addr_s),
    .mem_write_data(wdata_s), .mem_read_data(rdata_s)
  );

  // Single-port RAM model with a registered read. A same-address write
  // returns the old data. Reset clears the array, so a run with blocked
  // writes sees all zeros.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) ram[i] <= 4'h0;
      mem_read_data <= 4'h0;
    end else begin
      mem_read_data <= ram[mem_address];
      if (mem_write_en && !block_wr) begin
        if (stuck5 && (mem_address == 4'd5))
          ram[mem_address] <= mem_write_data & 4'hE;
        else
          ram[mem_address] <= mem_write_data;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Pulse start for one edge (E0). The caller is #1 after an edge; this
  // returns #1 after E0.
  task automatic applyStimulus(input logic [3:0] s);
    seed  = s;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // State right after E0: running, results cleared, writing P(0) = seed.
  task automatic checkStarted(input logic [3:0] s);
    checkOutput("e0_busy",  32'(busy), 32'd1);
    checkOutput("e0_done",  32'(done), 32'd0);
    checkOutput("e0_pass",  32'(pass), 32'd0);
    checkOutput("e0_err",   32'(err_count), 32'd0);
    checkOutput("e0_fail",  32'(fail_addr), 32'd0);
    checkOutput("e0_we",    32'(mem_write_en), 32'd1);
    checkOutput("e0_addr",  32'(mem_address), 32'd0);
    checkOutput("e0_wdata", 32'(mem_write_data), 32'(s));
  endtask

  // Step from E0 through E49, optionally pulsing start at two cycles, and
  // check the element boundaries, the exact completion edge and the results.
  task automatic runToDone(input logic [3:0] s, input int pa, input int pb,
                           input logic exp_pass, input logic [7:0] exp_err,
                           input logic [3:0] exp_fail);
    logic [3:0] inv_s;
    inv_s = ~s;
    for (int cyc = 1; cyc <= 49; cyc++) begin
      @(posedge clk); #1;
      start = (cyc == pa) || (cyc == pb);
      if (cyc == 16) begin
        checkOutput("rwup_we",    32'(mem_write_en), 32'd1);
        checkOutput("rwup_addr",  32'(mem_address), 32'd0);
        checkOutput("rwup_wdata", 32'(mem_write_data), 32'(inv_s));
      end
      if (cyc == 32) begin
        checkOutput("rdn_we",   32'(mem_write_en), 32'd0);
        checkOutput("rdn_addr", 32'(mem_address), 32'd15);
      end
      if (cyc == 48) begin
        checkOutput("e48_done", 32'(done), 32'd0);
        checkOutput("e48_busy", 32'(busy), 32'd1);
      end
    end
    start = 1'b0;
    checkOutput("e49_done", 32'(done), 32'd1);
    checkOutput("e49_busy", 32'(busy), 32'd0);
    checkOutput("e49_we",   32'(mem_write_en), 32'd0);
    checkOutput("pass",     32'(pass), 32'(exp_pass));
    checkOutput("err",      32'(err_count), 32'(exp_err));
    checkOutput("fail",     32'(fail_addr), 32'(exp_fail));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; seed = 4'h0; stuck5 = 1'b0; block_wr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_busy",  32'(busy), 32'd0);
    checkOutput("rst_done",  32'(done), 32'd0);
    checkOutput("rst_pass",  32'(pass), 32'd0);
    checkOutput("rst_err",   32'(err_count), 32'd0);
    checkOutput("rst_fail",  32'(fail_addr), 32'd0);
    checkOutput("rst_we",    32'(mem_write_en), 32'd0);
    checkOutput("rst_addr",  32'(mem_address), 32'd0);
    checkOutput("rst_wdata", 32'(mem_write_data), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: fault-free run, seed 0. The saturating instance runs alongside it
    // with seed F and sees 30 miscompares, the first at address 0.
    $display("[TB] fault-free run");
    applyStimulus(4'h0);
    checkStarted(4'h0);
    runToDone(4'h0, 0, 0, 1'b1, 8'd0, 4'd0);
    checkOutput("sat_done", 32'(done_s), 32'd1);
    checkOutput("sat_pass", 32'(pass_s), 32'd0);
    checkOutput("sat_err",  32'(err_s), 32'd3);
    checkOutput("sat_fail", 32'(fail_s), 32'd0);

    // 2: cell 5 bit 0 stuck at 0 with seed 1. RW_UP reads back 4 correctly,
    // and R_DN reads A where B was written.
    $display("[TB] stuck-at cell 5");
    stuck5 = 1'b1;
    applyStimulus(4'h1);
    checkStarted(4'h1);
    runToDone(4'h1, 0, 0, 1'b0, 8'd1, 4'd5);
    stuck5 = 1'b0;

    // 3: writes blocked so every cell reads 0, seed F. 15 miscompares in
    // RW_UP and 15 in R_DN, the first at address 0.
    $display("[TB] blocked writes");
    block_wr = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    applyStimulus(4'hF);
    checkStarted(4'hF);
    runToDone(4'hF, 0, 0, 1'b0, 8'd30, 4'd0);
    block_wr = 1'b0;

    // 4: start pulses during the run are ignored.
    $display("[TB] start while busy");
    applyStimulus(4'h0);
    checkStarted(4'h0);
    runToDone(4'h0, 10, 30, 1'b1, 8'd0, 4'd0);

    // 5: reset inside RW_UP, then a clean rerun.
    $display("[TB] mid-test reset");
    applyStimulus(4'h0);
    for (int cyc = 1; cyc <= 19; cyc++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("mrst_busy",  32'(busy), 32'd0);
    checkOutput("mrst_done",  32'(done), 32'd0);
    checkOutput("mrst_pass",  32'(pass), 32'd0);
    checkOutput("mrst_err",   32'(err_count), 32'd0);
    checkOutput("mrst_fail",  32'(fail_addr), 32'd0);
    checkOutput("mrst_we",    32'(mem_write_en), 32'd0);
    checkOutput("mrst_addr",  32'(mem_address), 32'd0);
    checkOutput("mrst_wdata", 32'(mem_write_data), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("mrst_we2", 32'(mem_write_en), 32'd0);
    applyStimulus(4'h3);
    checkStarted(4'h3);
    runToDone(4'h3, 0, 0, 1'b1, 8'd0, 4'd0);

    // 6: a failing run, then a restart one cycle after done with seed A.
    // The restart clears results at its sampling edge.
    $display("[TB] restart from done");
    stuck5 = 1'b1;
    applyStimulus(4'h1);
    runToDone(4'h1, 0, 0, 1'b0, 8'd1, 4'd5);
    stuck5 = 1'b0;
    applyStimulus(4'hA);
    checkStarted(4'hA);
    runToDone(4'hA, 0, 0, 1'b1, 8'd0, 4'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
